exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand and result width.
REQ-002 SHALL have port clk_i input 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i input 1, reset: asynchronous, active-low.
REQ-004 SHALL have port valid_i input 1, meaning an operation is presented this cycle.
REQ-005 SHALL have port ready_o output 1, meaning the unit accepts an operation this cycle.
REQ-006 SHALL have port ALUCtrl_i input 4, the ALU control code from the ALU controller.
REQ-007 SHALL have port src1_i input DATA_W, operand 1 (rs; shift amount for SHR).
REQ-008 SHALL have port src2_i input DATA_W, operand 2 (rt or immediate; shifted value for SHR).
REQ-009 SHALL have port kill_i input 1, synchronous flush from the pipeline hazard logic.
REQ-010 SHALL have port result_o output DATA_W, the registered result.
REQ-011 SHALL have port zero_o output 1, high when result_o equals 0.
REQ-012 SHALL have port valid_o output 1, a one-cycle pulse marking a new result_o.
REQ-013 SHALL have port busy_o output 1, the pipeline stall request, equal to NOT ready_o.

Function
REQ-014 SHALL accept an operation on a rising edge where valid_i and ready_o are high and kill_i is low.
REQ-015 SHALL decode codes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1000 SHR, 0100 MUL, 1111 IDLE.
REQ-016 SHALL compute ADD/SUB modulo 2^DATA_W with no overflow flag.
REQ-017 SHALL compute SLT as a signed compare src1_i < src2_i, with result 1 or 0.
REQ-018 SHALL compute SHR as src2_i arithmetic-shifted right by src1_i[4:0].
REQ-019 SHALL treat IDLE and every unlisted code as producing result 0.
REQ-020 SHALL implement states IDLE and MUL, with ready_o high only in IDLE.
REQ-021 SHALL register a single-cycle op's result in IDLE and pulse valid_o on the next cycle, staying in IDLE for back-to-back issue at a throughput of 1 op/cycle.
REQ-022 SHALL, on MUL accept, load multiplicand=src1_i, multiplier=src2_i, acc=0, count=0, and enter MUL.
REQ-023 SHALL, each cycle in MUL, add the multiplicand to acc when multiplier[0] is high, shift the multiplicand left by 1 and the multiplier right by 1, and increment count.
REQ-024 SHALL, on the iteration where count==DATA_W-1, write the low DATA_W bits of the product to result_o, return to IDLE, and pulse valid_o in the following cycle (fixed latency DATA_W cycles from accept, with no early termination).
REQ-025 SHALL ignore valid_i while in MUL.
REQ-026 SHALL, on kill_i high in MUL, return to IDLE next edge with no valid_o and result_o unchanged.
REQ-027 SHALL, on kill_i high in IDLE, drop any presented operation, with no valid_o.
REQ-028 SHALL give kill_i priority over completion when kill_i is high on the final MUL iteration.
REQ-029 SHALL hold result_o between valid_o pulses, and SHALL drive zero_o combinationally from result_o.

Reset
REQ-030 SHALL, on rst_i low, asynchronously force state=IDLE, result_o=0, valid_o=0, count=0, acc=0.
REQ-031 SHALL, after reset, have zero_o=1, ready_o=1, busy_o=0.
REQ-032 SHALL abandon an in-progress MUL on reset mid-operation, with no valid_o after release.

Structure
REQ-033 SHALL take the ALU control code constants and the state encoding from a shared package exec_pkg, also used by the ALU controller.
REQ-034 SHALL place the shift-add iterator (acc, multiplicand, multiplier, count) in sub-module exec_mul_iter with start/kill/done.

Verification
REQ-035 SHALL cover ADD 7+(-3) -> result_o=4 with valid_o one cycle later; SUB 5-5 -> 0 with zero_o=1.
REQ-036 SHALL cover back-to-back SLT(-1,1), OR(0xF0,0x0F), SHR(src1=4, src2=0x80000000) -> 1, 0xFF, 0xF8000000 on consecutive cycles.
REQ-037 SHALL cover MUL 6*(-7) -> 0xFFFFFFD6 with valid_o exactly 32 cycles after accept, busy_o high throughout, and a valid_i during MUL ignored.
REQ-038 SHALL cover kill_i asserted in MUL cycle 10 -> IDLE next cycle, no valid_o, result_o unchanged.
REQ-039 SHALL cover rst_i low in MUL cycle 20 -> immediate IDLE, result_o=0, no valid_o after release.
REQ-040 SHALL cover code 1111 and code 0011 -> result_o=0, zero_o=1, valid_o pulsed.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : ALU control codes and execute-unit state encoding, shared
//                with the ALU controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SHR  = 4'b1000;
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit_if
//  Description : Operation issue / result bus between pipeline and exec_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [3:0]        ALUCtrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic              kill_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              valid_o;
    logic              busy_o;

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i, kill_i,
        input  ready_o, result_o, zero_o, valid_o, busy_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i, kill_i,
        output ready_o, result_o, zero_o, valid_o, busy_o
    );
endinterface : exec_unit_if
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : exec_mul_iter
//  Description : Shift-add multiplier, one partial product per cycle, fixed
//                DATA_W iterations.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_mul_iter #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              i_start,
    input  wire logic              i_kill,
    input  wire logic              i_run,
    input  wire logic [DATA_W-1:0] i_mcand,
    input  wire logic [DATA_W-1:0] i_mplier,
    output logic                   o_done,
    output logic [DATA_W-1:0]      o_product
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_addend;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    // Product includes the current iteration's partial term so it is valid
    // on the same edge that the last iteration executes.
    assign o_product = r_acc + w_addend;
    assign o_done    = i_run && (r_count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_count  <= '0;
        end else if (i_kill) begin
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_run) begin
            r_acc    <= o_product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end
endmodule : exec_mul_iter
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit
//  Description : Execute stage: single-cycle ALU ops plus iterative multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    exec_unit_if.slave bus
);
    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic [DATA_W-1:0] w_alu;
    logic              w_start;
    logic              w_load_single;
    logic              w_complete;
    logic              w_in_mul;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    assign w_in_mul = (r_state == ST_MUL);

    always_comb begin
        w_alu = '0;
        case (bus.ALUCtrl_i)
            ALU_ADD: w_alu = bus.src1_i + bus.src2_i;
            ALU_SUB: w_alu = bus.src1_i - bus.src2_i;
            ALU_AND: w_alu = bus.src1_i & bus.src2_i;
            ALU_OR:  w_alu = bus.src1_i | bus.src2_i;
            ALU_SLT: w_alu = {{(DATA_W-1){1'b0}},
                              ($signed(bus.src1_i) < $signed(bus.src2_i))};
            ALU_SHR: w_alu = $unsigned($signed(bus.src2_i) >>> bus.src1_i[4:0]);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_load_single = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.valid_i && !bus.kill_i) begin
                    if (bus.ALUCtrl_i == ALU_MUL) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_load_single = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // Kill wins over completion on the final iteration.
                if (bus.kill_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_mul_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_load_single | w_complete;
            if (w_load_single) begin
                r_result <= w_alu;
            end else if (w_complete) begin
                r_result <= w_product;
            end
        end
    end

    exec_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_start   (w_start),
        .i_kill    (w_in_mul && bus.kill_i),
        .i_run     (w_in_mul),
        .i_mcand   (bus.src1_i),
        .i_mplier  (bus.src2_i),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign bus.result_o = r_result;
    assign bus.zero_o   = (r_result == '0);
    assign bus.valid_o  = r_valid;
    assign bus.ready_o  = !w_in_mul;
    assign bus.busy_o   = w_in_mul;
endmodule : exec_unit
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_unit
//  Description : Directed self-checking bench for exec_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit;
    import exec_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic saw_valid;

    exec_unit_if #(.DATA_W(32)) bus ();

    exec_unit #(.DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = v;
        bus.ALUCtrl_i = op;
        bus.src1_i    = a;
        bus.src2_i    = b;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.kill_i  = 1'b0;
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);

        #12;
        check_eq("rst_result", bus.result_o, 32'd0);
        check_eq("rst_zero",   bus.zero_o,   1'b1);
        check_eq("rst_ready",  bus.ready_o,  1'b1);
        check_eq("rst_busy",   bus.busy_o,   1'b0);
        check_eq("rst_valid",  bus.valid_o,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD 7 + (-3)
        drive(1'b1, ALU_ADD, 32'd7, 32'hFFFF_FFFD);
        check_eq("add_valid_before", bus.valid_o, 1'b0);
        tick();
        check_eq("add_result", bus.result_o, 32'd4);
        check_eq("add_valid",  bus.valid_o,  1'b1);
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        tick();
        check_eq("add_pulse_end", bus.valid_o,  1'b0);
        check_eq("add_hold",      bus.result_o, 32'd4);

        // SUB 5 - 5
        drive(1'b1, ALU_SUB, 32'd5, 32'd5);
        tick();
        check_eq("sub_result", bus.result_o, 32'd0);
        check_eq("sub_zero",   bus.zero_o,   1'b1);
        check_eq("sub_valid",  bus.valid_o,  1'b1);

        // Back-to-back SLT, OR, SHR
        drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        check_eq("slt_result", bus.result_o, 32'd1);
        check_eq("slt_valid",  bus.valid_o,  1'b1);
        check_eq("slt_ready",  bus.ready_o,  1'b1);
        drive(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        tick();
        check_eq("or_result", bus.result_o, 32'h0000_00FF);
        check_eq("or_valid",  bus.valid_o,  1'b1);
        drive(1'b1, ALU_SHR, 32'd4, 32'h8000_0000);
        tick();
        check_eq("shr_result", bus.result_o, 32'hF800_0000);
        check_eq("shr_valid",  bus.valid_o,  1'b1);
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        tick();
        check_eq("b2b_pulse_end", bus.valid_o, 1'b0);

        // MUL 6 * (-7), with an ignored issue attempt while busy
        drive(1'b1, ALU_MUL, 32'd6, 32'hFFFF_FFF9);
        tick();
        check_eq("mul_busy_start",  bus.busy_o,  1'b1);
        check_eq("mul_ready_start", bus.ready_o, 1'b0);
        check_eq("mul_valid_start", bus.valid_o, 1'b0);
        drive(1'b1, ALU_ADD, 32'd1, 32'd1);
        for (int k = 1; k <= 31; k++) begin
            if (k == 31) bus.valid_i = 1'b0;
            tick();
            check_eq("mul_wait_valid", bus.valid_o, 1'b0);
            check_eq("mul_wait_busy",  bus.busy_o,  1'b1);
        end
        tick();
        check_eq("mul_valid",  bus.valid_o,  1'b1);
        check_eq("mul_result", bus.result_o, 32'hFFFF_FFD6);
        check_eq("mul_ready",  bus.ready_o,  1'b1);
        check_eq("mul_busy",   bus.busy_o,   1'b0);
        tick();
        check_eq("mul_pulse_end", bus.valid_o,  1'b0);
        check_eq("mul_hold",      bus.result_o, 32'hFFFF_FFD6);

        // Kill in MUL cycle 10
        drive(1'b1, ALU_MUL, 32'd3, 32'd5);
        tick();
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        repeat (9) tick();
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        check_eq("kill_ready",  bus.ready_o,  1'b1);
        check_eq("kill_valid",  bus.valid_o,  1'b0);
        check_eq("kill_result", bus.result_o, 32'hFFFF_FFD6);
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (bus.valid_o) saw_valid = 1'b1;
        end
        check_eq("kill_no_late_valid", saw_valid, 1'b0);

        // Reset in MUL cycle 20
        drive(1'b1, ALU_MUL, 32'd2, 32'd3);
        tick();
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        repeat (19) tick();
        check_eq("rstmul_busy_before", bus.busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmul_ready",  bus.ready_o,  1'b1);
        check_eq("rstmul_result", bus.result_o, 32'd0);
        check_eq("rstmul_zero",   bus.zero_o,   1'b1);
        check_eq("rstmul_valid",  bus.valid_o,  1'b0);
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (bus.valid_o) saw_valid = 1'b1;
        end
        check_eq("rstmul_no_valid", saw_valid, 1'b0);

        // Kill on the final MUL iteration takes priority
        drive(1'b1, ALU_ADD, 32'd1, 32'd2);
        tick();
        check_eq("pre_final_result", bus.result_o, 32'd3);
        drive(1'b1, ALU_MUL, 32'd2, 32'd2);
        tick();
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        repeat (31) tick();
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        check_eq("final_kill_valid",  bus.valid_o,  1'b0);
        check_eq("final_kill_result", bus.result_o, 32'd3);
        check_eq("final_kill_ready",  bus.ready_o,  1'b1);
        tick();
        check_eq("final_kill_late", bus.valid_o, 1'b0);

        // Kill in IDLE drops the presented op
        bus.kill_i = 1'b1;
        drive(1'b1, ALU_ADD, 32'd10, 32'd20);
        tick();
        bus.kill_i = 1'b0;
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        check_eq("idle_kill_valid",  bus.valid_o,  1'b0);
        check_eq("idle_kill_result", bus.result_o, 32'd3);

        // MUL wrap: (-1) * (-1) -> 1
        drive(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        repeat (31) tick();
        check_eq("mul2_valid_early", bus.valid_o, 1'b0);
        tick();
        check_eq("mul2_valid",  bus.valid_o,  1'b1);
        check_eq("mul2_result", bus.result_o, 32'd1);

        // IDLE code and an unlisted code both give 0
        drive(1'b1, 4'b1111, 32'd5, 32'd6);
        tick();
        check_eq("code_f_result", bus.result_o, 32'd0);
        check_eq("code_f_zero",   bus.zero_o,   1'b1);
        check_eq("code_f_valid",  bus.valid_o,  1'b1);
        drive(1'b1, ALU_AND, 32'h0000_00F3, 32'h0000_001F);
        tick();
        check_eq("and_result", bus.result_o, 32'h0000_0013);
        check_eq("and_zero",   bus.zero_o,   1'b0);
        drive(1'b1, 4'b0011, 32'd9, 32'd9);
        tick();
        check_eq("code_3_result", bus.result_o, 32'd0);
        check_eq("code_3_zero",   bus.zero_o,   1'b1);
        check_eq("code_3_valid",  bus.valid_o,  1'b1);
        drive(1'b0, ALU_IDLE, 32'd0, 32'd0);
        tick();
        check_eq("end_valid", bus.valid_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_exec_unit
`default_nettype wire
